// File: rtl/logic_op_scheduler.sv
// Two-requester front end for a shared bit-serial logic cell built from NAND gates.
// Round-robin grant, LSB-first sequencing over WIDTH cycles, id-tagged valid/ready result.

module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module logic_op_cell (
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);
  logic n_ab, n_aa, n_bb, and_y, or_y, x_a, x_b, xor_y;

  // Every function is derived from NAND so the cell maps onto the gate-level datapath.
  nand_gate u_nab (.a(a),    .b(b),    .y(n_ab));
  nand_gate u_naa (.a(a),    .b(a),    .y(n_aa));
  nand_gate u_nbb (.a(b),    .b(b),    .y(n_bb));
  nand_gate u_and (.a(n_ab), .b(n_ab), .y(and_y));
  nand_gate u_or  (.a(n_aa), .b(n_bb), .y(or_y));
  nand_gate u_xa  (.a(a),    .b(n_ab), .y(x_a));
  nand_gate u_xb  (.a(b),    .b(n_ab), .y(x_b));
  nand_gate u_xor (.a(x_a),  .b(x_b),  .y(xor_y));

  always_comb begin
    y = and_y;
    case (op)
      2'b00:   y = and_y;
      2'b01:   y = or_y;
      2'b10:   y = xor_y;
      default: y = n_ab;
    endcase
  end
endmodule

module logic_op_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg;
  logic [1:0]       op_reg;
  logic             id_reg, last_grant_reg;
  logic             grant, accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             cell_y;
  logic [WIDTH-1:0] bit_we;

  // On a tie the requester not served last time wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid)
      grant = ~last_grant_reg;
  end

  assign accept = (state_reg == IDLE) && (req0_valid || req1_valid);
  assign sel_op = grant ? req1_op : req0_op;
  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;

  logic_op_cell u_cell (
    .a  (a_reg[cnt_reg]),
    .b  (b_reg[cnt_reg]),
    .op (op_reg),
    .y  (cell_y)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit_we
      assign bit_we[gi] = (state_reg == BUSY) && (cnt_reg == CW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (cnt_reg == LAST_BIT) state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= 2'b00;
      result_reg     <= '0;
      id_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      cnt_reg        <= '0;
      a_reg          <= sel_a;
      b_reg          <= sel_b;
      op_reg         <= sel_op;
      result_reg     <= '0;
      id_reg         <= grant;
      last_grant_reg <= grant;
    end else if (state_reg == BUSY) begin
      cnt_reg        <= cnt_reg + 1'b1;
      result_reg     <= (result_reg & ~bit_we) | (bit_we & {WIDTH{cell_y}});
    end
  end

  always_comb begin
    req0_ready = (state_reg == IDLE) && !grant && req0_valid;
    req1_ready = (state_reg == IDLE) &&  grant && req1_valid;
    res_valid  = (state_reg == DONE);
    res_data   = (state_reg == DONE) ? result_reg : '0;
    res_id     = id_reg;
  end
endmodule
